// File: rtl/fetch_seq_pkg.sv
// fetch_seq shared types: FSM states, next-PC selects, default widths.
package fetch_seq_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_STACK_D = 4;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_SKIP,
    SEL_INC
  } npc_sel_t;

endpackage

// File: rtl/fetch_seq_ret_stack.sv
// ret_stack: pointer-based LIFO of return addresses, synchronous clear.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] w_tos;

  assign full  = (r_ptr == PW'(DEPTH));
  assign empty = (r_ptr == '0);
  assign w_tos = r_ptr - PW'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_tos == PW'(i)) top = r_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_ptr <= '0;
    end else if (push && !full) begin
      r_ptr <= r_ptr + PW'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - PW'(1);
    end
  end

  // Contents need no reset: only entries below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (!clear && push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ptr == PW'(i)) r_mem[i] <= din;
      end
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: req/ack program sequencer with next-PC resolution.
// Return stack enabled by defining FETCH_SEQ_STACK_EN.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int STACK_D    = DEF_STACK_D,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int START_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             ack,
  input  logic             stall,
  input  logic             jump_en,
  input  logic             branch_skip,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt,
  input  logic [PC_W-1:0]  jump_addr,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             stack_err,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  npc_sel_t         w_sel;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] r_cnt;

`ifdef FETCH_SEQ_STACK_EN
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;
  logic            w_full;
  logic            w_empty;
  logic [PC_W-1:0] w_top;
  logic            r_err;
`else
  logic            w_unused_ret;
  assign w_unused_ret = ret_en;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = SEL_HOLD;
`ifdef FETCH_SEQ_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: if (req) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!stall) begin
          priority case (1'b1)
            halt: w_state_nxt = S_DONE;
`ifdef FETCH_SEQ_STACK_EN
            ret_en: begin
              if (w_empty) begin
                w_err_set   = 1'b1;
                w_state_nxt = S_DONE;
              end else begin
                w_pop = 1'b1;
                w_sel = SEL_RET;
              end
            end
            call_en: begin
              w_sel = SEL_CALL;
              if (w_full) w_err_set = 1'b1;
              else        w_push    = 1'b1;
            end
            jump_en:     w_sel = SEL_JUMP;
`else
            call_en,
            jump_en:     w_sel = SEL_JUMP;
`endif
            branch_skip: w_sel = SEL_SKIP;
            default:     w_sel = SEL_INC;
          endcase
        end
      end
      S_DONE:  if (!req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (r_state == S_IDLE) begin
      w_pc_nxt = START_PC;
    end else begin
      unique case (w_sel)
`ifdef FETCH_SEQ_STACK_EN
        SEL_RET:  w_pc_nxt = w_top;
        SEL_CALL: w_pc_nxt = jump_addr;
`endif
        SEL_JUMP: w_pc_nxt = jump_addr;
        SEL_SKIP: w_pc_nxt = r_pc + PC_W'(2);
        SEL_INC:  w_pc_nxt = r_pc + PC_W'(1);
        default:  w_pc_nxt = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      // Counter is kept through DONE/IDLE and cleared only on a new start.
      if (r_state == S_IDLE && req) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FETCH_SEQ_STACK_EN
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  ret_stack #(
    .DEPTH (STACK_D),
    .W     (PC_W)
  ) u_ret_stack (
    .clk   (clk),
    .clear (reset || r_state == S_IDLE),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_pc + PC_W'(1)),
    .full  (w_full),
    .empty (w_empty),
    .top   (w_top)
  );

  assign stack_err = r_err;
`else
  assign stack_err = 1'b0;
`endif

  assign pc        = r_pc;
  assign running   = (r_state == S_RUN);
  assign ack       = (r_state == S_DONE);
  assign cycle_cnt = r_cnt;

endmodule
